param_branch_predictor: RTL and testbench

PARAM_BRANCH_PREDICTOR -- requirements
Module: param_branch_predictor

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_sat_ctr.sv | 44 ++++
 rtl/param_branch_predictor.sv | 145 ++++++++++++++
 tb/tb_param_branch_predictor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the parameterised branch predictor.
//   ctr_e          - 2-bit direction counter state (00 strong-NT .. 11 strong-T)
//   BP_*           - default geometry for param_branch_predictor
//   bp_sat_update  - one saturating step of a direction counter
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int BP_ADDR_W   = 16;
    localparam int BP_IDX_BITS = 3;
    localparam int BP_TAG_BITS = 4;

    // Move one step toward strong-taken (taken=1) or strong-not-taken
    // (taken=0), sticking at either end.
    function automatic ctr_e bp_sat_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: one 2-bit saturating direction counter.
// Ports:
//   clk, rst_n   - clock, async active-low reset (resets to weak-not-taken)
//   inc_i        - step toward strong-taken
//   dec_i        - step toward strong-not-taken
//   load_i       - overwrite with load_val_i (wins over inc/dec)
//   load_val_i   - value used on load
//   ctr_o        - current counter state
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    input  logic load_i,
    input  ctr_e load_val_i,
    output ctr_e ctr_o
);

    ctr_e ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = load_val_i;
        end else if (inc_i) begin
            ctr_d = bp_sat_update(ctr_q, 1'b1);
        end else if (dec_i) begin
            ctr_d = bp_sat_update(ctr_q, 1'b0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/param_branch_predictor.sv
// param_branch_predictor: direct-mapped branch predictor / BTB.
// Each of the 2**IDX_BITS entries holds a valid bit, a 2-bit saturating
// direction counter, a target address and (with BP_TAG_EN) a tag.
// Lookup is purely combinational; updates land on the rising edge.
// Configuration macro: BP_TAG_EN - when defined, tags are stored and compared
// on both lookup and update; otherwise aliasing PCs share an entry.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   enable            - permits table updates (low = stall)
//   flush             - synchronous clear of every valid bit
//   lookup_pc         - fetch-stage PC
//   update_valid/pc/taken/target - resolved branch information
//   hit               - lookup entry valid (and tag match)
//   predicted_taken   - hit and counter predicts taken
//   predicted_target  - stored target on hit, else 0
//   next_pc           - predicted target when taken, else lookup_pc+2
module param_branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W   = BP_ADDR_W,
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int TAG_BITS = BP_TAG_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_pc,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    output logic              hit,
    output logic              predicted_taken,
    output logic [ADDR_W-1:0] predicted_target,
    output logic [ADDR_W-1:0] next_pc
);

    localparam int N_ENT = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] lk_idx;
    logic [IDX_BITS-1:0] up_idx;
    logic                lk_hit;
    logic                up_hit;
    logic                upd_fire;
    logic                alloc;
    logic                wr_tgt;
    logic [1:0]          lk_ctr;

    logic [N_ENT-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   target_q [N_ENT];
    ctr_e                ctr_q    [N_ENT];

    // pc[0] never participates; the index starts at bit 1.
    assign lk_idx = lookup_pc[IDX_BITS:1];
    assign up_idx = update_pc[IDX_BITS:1];

`ifdef BP_TAG_EN
    logic [TAG_BITS-1:0] tag_q [N_ENT];
    logic [TAG_BITS-1:0] lk_tag;
    logic [TAG_BITS-1:0] up_tag;

    assign lk_tag = lookup_pc[IDX_BITS+TAG_BITS:IDX_BITS+1];
    assign up_tag = update_pc[IDX_BITS+TAG_BITS:IDX_BITS+1];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Tags are only written on allocation; on a hit they already match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (alloc) begin
            tag_q[up_idx] <= up_tag;
        end
    end
`else
    localparam int unused_tag_bits = TAG_BITS;

    assign lk_hit = valid_q[lk_idx];
    assign up_hit = valid_q[up_idx];
`endif

    // Only the index (and tag) bits of update_pc matter.
    logic unused_update_pc;
    assign unused_update_pc = ^update_pc;

    assign upd_fire = update_valid && enable && !flush;
    assign alloc    = upd_fire && !up_hit && update_taken;
    // Target is refreshed on any taken update, hit or allocate.
    assign wr_tgt   = upd_fire && update_taken;

    // Flush is not gated by enable: a redirect must clear the table even
    // while the pipeline is otherwise stalled.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (alloc) begin
            valid_d[up_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                target_q[i] <= '0;
            end
        end else if (wr_tgt) begin
            target_q[up_idx] <= update_target;
        end
    end

    for (genvar g = 0; g < N_ENT; g++) begin : g_ctr
        logic sel;
        assign sel = upd_fire && (up_idx == IDX_BITS'(g));

        bp_sat_ctr u_ctr (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc_i      (sel && up_hit && update_taken),
            .dec_i      (sel && up_hit && !update_taken),
            .load_i     (sel && !up_hit && update_taken),
            .load_val_i (CTR_WT),
            .ctr_o      (ctr_q[g])
        );
    end

    assign lk_ctr           = ctr_q[lk_idx];
    assign hit              = lk_hit;
    assign predicted_taken  = lk_hit && lk_ctr[1];
    assign predicted_target = lk_hit ? target_q[lk_idx] : '0;
    assign next_pc          = predicted_taken ? predicted_target
                                              : lookup_pc + ADDR_W'(2);

endmodule

// File: tb/tb_param_branch_predictor.sv
module tb_param_branch_predictor;

`ifdef BP_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [15:0] lookup_pc;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        hit;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic [15:0] next_pc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    param_branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .flush            (flush),
        .lookup_pc        (lookup_pc),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .hit              (hit),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .next_pc          (next_pc)
    );

    // ---------------- behavioural model ----------------
    int m_valid [8];
    int m_tag   [8];
    int m_ctr   [8];
    int m_tgt   [8];

    function automatic int f_idx(input logic [15:0] pc);
        return (int'(pc) >> 1) % 8;
    endfunction

    function automatic int f_tag(input logic [15:0] pc);
        return (int'(pc) >> 4) % 16;
    endfunction

    function automatic bit m_hit_at(input logic [15:0] pc);
        return (m_valid[f_idx(pc)] != 0) && (!TAG_EN || m_tag[f_idx(pc)] == f_tag(pc));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] <= 0;
                m_tag[i]   <= 0;
                m_ctr[i]   <= 1;
                m_tgt[i]   <= 0;
            end
        end else if (flush) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 0;
        end else if (update_valid && enable) begin
            if (m_hit_at(update_pc)) begin
                if (update_taken) begin
                    m_ctr[f_idx(update_pc)] <= (m_ctr[f_idx(update_pc)] == 3) ? 3 : m_ctr[f_idx(update_pc)] + 1;
                    m_tgt[f_idx(update_pc)] <= int'(update_target);
                end else begin
                    m_ctr[f_idx(update_pc)] <= (m_ctr[f_idx(update_pc)] == 0) ? 0 : m_ctr[f_idx(update_pc)] - 1;
                end
            end else if (update_taken) begin
                m_valid[f_idx(update_pc)] <= 1;
                m_tag[f_idx(update_pc)]   <= f_tag(update_pc);
                m_ctr[f_idx(update_pc)]   <= 2;
                m_tgt[f_idx(update_pc)]   <= int'(update_target);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        bit          e_hit;
        bit          e_pt;
        logic [15:0] e_tgt;
        logic [15:0] e_next;
        e_hit  = m_hit_at(lookup_pc);
        e_pt   = e_hit && (m_ctr[f_idx(lookup_pc)] >= 2);
        e_tgt  = e_hit ? 16'(m_tgt[f_idx(lookup_pc)]) : 16'h0000;
        e_next = e_pt ? e_tgt : 16'((int'(lookup_pc) + 2) % 65536);
        chk("model_hit",  {15'd0, hit},             {15'd0, e_hit});
        chk("model_pt",   {15'd0, predicted_taken}, {15'd0, e_pt});
        chk("model_tgt",  predicted_target,         e_tgt);
        chk("model_next", next_pc,                  e_next);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tgt;
    endtask

    task automatic idle();
        update_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b1;
        flush = 1'b0;
        lookup_pc = 16'h0010;
        update_valid = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;
        update_target = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hit",  {15'd0, hit}, 16'd0);
        chk("rst_pt",   {15'd0, predicted_taken}, 16'd0);
        chk("rst_tgt",  predicted_target, 16'h0000);
        chk("rst_next", next_pc, 16'h0012);
        tick();
        rst_n = 1'b1;

        // Allocate 0x0010 -> 0x0040
        upd(16'h0010, 1'b1, 16'h0040);
        tick(); idle(); #1;
        chk("alloc_hit",  {15'd0, hit}, 16'd1);
        chk("alloc_pt",   {15'd0, predicted_taken}, 16'd1);
        chk("alloc_next", next_pc, 16'h0040);

        // Two not-taken: 10 -> 01 -> 00; target untouched
        upd(16'h0010, 1'b0, 16'h0777);
        tick(); tick(); idle(); #1;
        chk("nt2_hit",  {15'd0, hit}, 16'd1);
        chk("nt2_pt",   {15'd0, predicted_taken}, 16'd0);
        chk("nt2_tgt",  predicted_target, 16'h0040);
        chk("nt2_next", next_pc, 16'h0012);

        // Third not-taken holds 00, then one taken -> 01 (still not taken)
        upd(16'h0010, 1'b0, 16'h0777);
        tick();
        upd(16'h0010, 1'b1, 16'h0040);
        tick(); idle(); #1;
        chk("sat_low_pt", {15'd0, predicted_taken}, 16'd0);

        // 0x0004: three taken -> 11, fourth holds, one not-taken -> 10
        lookup_pc = 16'h0004;
        upd(16'h0004, 1'b1, 16'h0100);
        tick(); tick(); tick(); idle(); #1;
        chk("t3_pt", {15'd0, predicted_taken}, 16'd1);
        upd(16'h0004, 1'b1, 16'h0100);
        tick();
        upd(16'h0004, 1'b0, 16'h0100);
        tick(); idle(); #1;
        chk("sat_high_pt",   {15'd0, predicted_taken}, 16'd1);
        chk("sat_high_next", next_pc, 16'h0100);

        // Alias 0x0024: same index, different tag
        lookup_pc = 16'h0024; #1;
        chk("alias_hit",  {15'd0, hit}, TAG_EN ? 16'd0 : 16'd1);
        chk("alias_tgt",  predicted_target, TAG_EN ? 16'h0000 : 16'h0100);
        chk("alias_next", next_pc, TAG_EN ? 16'h0026 : 16'h0100);
        upd(16'h0024, 1'b1, 16'h0300);
        tick(); idle(); #1;
        chk("realloc_tgt", predicted_target, 16'h0300);
        lookup_pc = 16'h0004; #1;
        chk("evicted_hit", {15'd0, hit}, TAG_EN ? 16'd0 : 16'd1);

        // Same-cycle lookup and update on an empty index
        lookup_pc = 16'h0008;
        upd(16'h0008, 1'b1, 16'h0200);
        #1;
        chk("same_cyc_pre", {15'd0, hit}, 16'd0);
        tick(); idle(); #1;
        chk("same_cyc_post",  {15'd0, hit}, 16'd1);
        chk("same_cyc_next",  next_pc, 16'h0200);

        // Flush with a simultaneous update
        flush = 1'b1;
        upd(16'h000C, 1'b1, 16'h0400);
        tick(); flush = 1'b0; idle();
        lookup_pc = 16'h0008; #1;
        chk("flush_clr", {15'd0, hit}, 16'd0);
        lookup_pc = 16'h000C; #1;
        chk("flush_noalloc", {15'd0, hit}, 16'd0);

        // Stall: enable low blocks the update, outputs stay live
        enable = 1'b0;
        upd(16'h000A, 1'b1, 16'h0500);
        lookup_pc = 16'h000A;
        tick(); tick();
        enable = 1'b1; idle(); #1;
        chk("stall_noupd",  {15'd0, hit}, 16'd0);
        chk("stall_next",   next_pc, 16'h000C);

        // next_pc wraps modulo 2**16
        lookup_pc = 16'hFFFF; #1;
        chk("wrap_next", next_pc, 16'h0001);

        // Async reset between edges
        lookup_pc = 16'h000A;
        upd(16'h000A, 1'b1, 16'h0500);
        tick(); idle(); #1;
        chk("pre_rst_hit", {15'd0, hit}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("async_hit",  {15'd0, hit}, 16'd0);
        chk("async_pt",   {15'd0, predicted_taken}, 16'd0);
        chk("async_tgt",  predicted_target, 16'h0000);
        chk("async_next", next_pc, 16'h000C);
        tick();
        rst_n = 1'b1; #1;
        chk("post_rst_hit", {15'd0, hit}, 16'd0);

        tick(); tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
